// File: rtl/memory_bus_pkg.sv
// Shared types for the multi-port memory bus: packet layout, packet kinds,
// requester identifiers, address and payload widths.
package memory_bus_pkg;

  localparam int BUS_ID_W  = 4;
  localparam int ADDR_W    = 32;
  localparam int PAYLOAD_W = 32;

  typedef logic [BUS_ID_W-1:0]  BusID;
  typedef logic [ADDR_W-1:0]    memory_address_t;
  typedef logic [PAYLOAD_W-1:0] bus_packet_payload_t;

  typedef enum logic [1:0] {
    bus_read_data     = 2'd0,
    bus_write_data    = 2'd1,
    bus_read_response = 2'd2
  } bus_packet_type_t;

  typedef struct packed {
    bus_packet_type_t    packet_type;
    BusID                source;
    memory_address_t     address;
    bus_packet_payload_t payload;
  } BusPacket;

endpackage

// File: rtl/bus_packet_fifo.sv
// Registered (non fall-through) packet FIFO used for every request and
// response buffer of the memory bus. Pushes are ignored when full and pops
// when empty; the head reads as zero while the FIFO is empty.
module bus_packet_fifo
  import memory_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  BusPacket push_packet,
  input  logic     pop,
  output BusPacket head,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  BusPacket           storage [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : storage[rd_ptr];

  // Packet storage is written only on an accepted push; contents need no reset
  // because the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= push_packet;
    end
  end

  // Pointers wrap naturally; count tracks occupancy, unchanged on push+pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multi_port_memory_bus.sv
// N-requester memory bus: per-port request/response FIFOs, a round-robin
// arbiter with grant lock onto the memory request channel, and routing of
// memory responses by source id. Optional tracing: MEMORY_BUS_TRACE_EN.
module multi_port_memory_bus
  import memory_bus_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req_valid,
  input  BusPacket             req_packet [NUM_PORTS],
  output logic [NUM_PORTS-1:0] req_ready,
  output logic [NUM_PORTS-1:0] rsp_valid,
  output BusPacket             rsp_packet [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] rsp_ready,
  output logic                 mem_req_valid,
  output BusPacket             mem_req_packet,
  input  logic                 mem_req_ready,
  input  logic                 mem_rsp_valid,
  input  BusPacket             mem_rsp_packet,
  output logic                 mem_rsp_ready,
  output logic                 err_bad_source
);

  localparam int GRANT_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] req_full, req_empty, req_pop;
  logic [NUM_PORTS-1:0] rsp_full, rsp_empty, rsp_push;
  BusPacket             req_head [NUM_PORTS];
  logic [GRANT_W-1:0]   rr_ptr, grant, hold_grant, search_grant, cand;
  logic                 hold_valid, any_pending, mem_req_fire, rsp_dest_bad;
  BusID                 rsp_dest;
  int                   idx;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    bus_packet_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (req_valid[i]),
      .push_packet (req_packet[i]),
      .pop         (req_pop[i]),
      .head        (req_head[i]),
      .full        (req_full[i]),
      .empty       (req_empty[i])
    );

    bus_packet_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (rsp_push[i]),
      .push_packet (mem_rsp_packet),
      .pop         (rsp_ready[i]),
      .head        (rsp_packet[i]),
      .full        (rsp_full[i]),
      .empty       (rsp_empty[i])
    );
  end

  assign req_ready = ~req_full & {NUM_PORTS{~reset}};
  assign rsp_valid = ~rsp_empty;
  assign rsp_dest  = mem_rsp_packet.source;

  // Round-robin search: first non-empty request FIFO starting at rr_ptr.
  always_comb begin
    search_grant = '0;
    any_pending  = 1'b0;
    idx          = 0;
    cand         = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx  = (int'(rr_ptr) + k) % NUM_PORTS;
      cand = GRANT_W'(idx);
      if (!any_pending && !req_empty[cand]) begin
        any_pending  = 1'b1;
        search_grant = cand;
      end
    end
  end

  // A stalled request keeps its grant so the memory side sees a stable packet.
  always_comb begin
    grant          = hold_valid ? hold_grant : search_grant;
    mem_req_valid  = hold_valid | any_pending;
    mem_req_packet = mem_req_valid ? req_head[grant] : '0;
    mem_req_fire   = mem_req_valid & mem_req_ready;
    req_pop        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (mem_req_fire && grant == GRANT_W'(i)) req_pop[i] = 1'b1;
    end
  end

  // Grant-lock register and round-robin pointer advance on each transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      hold_valid <= 1'b0;
      hold_grant <= '0;
    end else begin
      hold_valid <= mem_req_valid & ~mem_req_ready;
      hold_grant <= grant;
      if (mem_req_fire) begin
        rr_ptr <= (grant == GRANT_W'(NUM_PORTS-1)) ? '0 : grant + GRANT_W'(1);
      end
    end
  end

  // Route responses by source; unknown sources are always accepted and dropped.
  always_comb begin
    rsp_dest_bad  = 1'b1;
    mem_rsp_ready = 1'b1;
    rsp_push      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rsp_dest == BusID'(i)) begin
        rsp_dest_bad  = 1'b0;
        mem_rsp_ready = ~rsp_full[i];
        rsp_push[i]   = mem_rsp_valid & ~rsp_full[i];
      end
    end
  end

  // Sticky flag for a response naming a non-existent port, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_bad_source <= 1'b0;
    end else if (mem_rsp_valid && rsp_dest_bad) begin
      err_bad_source <= 1'b1;
    end
  end

`ifdef MEMORY_BUS_TRACE_EN
  // Trace memory requests, response pushes and the first bad-source event.
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_req_fire)
        $display("memory_bus: req port=%0d type=%s addr=%h",
                 grant, mem_req_packet.packet_type.name(), mem_req_packet.address);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (rsp_push[i])
          $display("memory_bus: rsp port=%0d payload=%h", i, mem_rsp_packet.payload);
      end
      if (mem_rsp_valid && rsp_dest_bad && !err_bad_source)
        $display("memory_bus: bad response source %0d", rsp_dest);
    end
  end
`else
  // Tracing disabled: no simulation output is produced.
`endif

endmodule

// File: tb/tb_multi_port_memory_bus.sv
// Directed self-checking bench for multi_port_memory_bus with scoreboard
// queues for memory requests and per-port responses.
module tb_multi_port_memory_bus;
  import memory_bus_pkg::*;

  localparam int NUM_PORTS = 4;
  localparam int REQ_DEPTH = 4;
  localparam int RSP_DEPTH = 2;

  logic                 clk;
  logic                 reset;
  logic [NUM_PORTS-1:0] req_valid;
  BusPacket             req_packet [NUM_PORTS];
  logic [NUM_PORTS-1:0] req_ready;
  logic [NUM_PORTS-1:0] rsp_valid;
  BusPacket             rsp_packet [NUM_PORTS];
  logic [NUM_PORTS-1:0] rsp_ready;
  logic                 mem_req_valid;
  BusPacket             mem_req_packet;
  logic                 mem_req_ready;
  logic                 mem_rsp_valid;
  BusPacket             mem_rsp_packet;
  logic                 mem_rsp_ready;
  logic                 err_bad_source;

  int checks = 0;
  int errors = 0;

  BusPacket exp_req_q  [$];
  BusPacket exp_rsp0_q [$];
  BusPacket exp_rsp2_q [$];
  BusPacket w_pkt [5];
  BusPacket p2, p3, pa, pb, pc, pd, pbad;

  multi_port_memory_bus #(
    .NUM_PORTS (NUM_PORTS),
    .REQ_DEPTH (REQ_DEPTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_packet     (req_packet),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_packet     (rsp_packet),
    .rsp_ready      (rsp_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_packet (mem_req_packet),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_packet (mem_rsp_packet),
    .mem_rsp_ready  (mem_rsp_ready),
    .err_bad_source (err_bad_source)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $error("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic BusPacket make_pkt(bus_packet_type_t t, int src, logic [31:0] addr,
                                        logic [31:0] data);
    BusPacket p;
    p.packet_type = t;
    p.source      = BusID'(src);
    p.address     = addr;
    p.payload     = data;
    return p;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_pkt(input string tag, input BusPacket observed, input BusPacket expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_queue_nonempty(input string tag, input int size);
    checks++;
    assert (size != 0) else begin
      errors++;
      $error("[TB] FAIL %s: observed=empty scoreboard required=pending entry", tag);
    end
  endtask

  task automatic expect_mem_req(input string tag);
    check_output({tag, "_valid"}, 32'(mem_req_valid), 32'd1);
    check_queue_nonempty({tag, "_sb"}, exp_req_q.size());
    if (exp_req_q.size() != 0) check_pkt({tag, "_pkt"}, mem_req_packet, exp_req_q.pop_front());
  endtask

  task automatic expect_rsp(input int port, input string tag);
    if (port == 0) begin
      check_queue_nonempty({tag, "_sb"}, exp_rsp0_q.size());
      if (exp_rsp0_q.size() != 0) check_pkt(tag, rsp_packet[0], exp_rsp0_q.pop_front());
    end else begin
      check_queue_nonempty({tag, "_sb"}, exp_rsp2_q.size());
      if (exp_rsp2_q.size() != 0) check_pkt(tag, rsp_packet[2], exp_rsp2_q.pop_front());
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_idle();
    req_valid      = '0;
    rsp_ready      = '0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_packet = '0;
    for (int i = 0; i < NUM_PORTS; i++) req_packet[i] = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    exp_req_q.delete();
    exp_rsp0_q.delete();
    exp_rsp2_q.delete();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus_idle();
    #2;
    $display("[TB] reset values");
    check_output("rst_req_ready", 32'(req_ready), 32'h0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check_output("rst_mem_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    check_output("rst_err", 32'(err_bad_source), 32'd0);
    check_pkt("rst_mem_req_pkt", mem_req_packet, '0);
    check_pkt("rst_rsp_pkt0", rsp_packet[0], '0);
    apply_reset();
    check_output("post_rst_req_ready", 32'(req_ready), 32'hF);

    $display("[TB] single read on port 0");
    req_valid[0]  = 1'b1;
    req_packet[0] = make_pkt(bus_read_data, 0, 32'h100, 32'h0);
    mem_req_ready = 1'b1;
    exp_req_q.push_back(req_packet[0]);
    #1;
    check_output("t1_no_fallthrough", 32'(mem_req_valid), 32'd0);
    next_cycle();
    req_valid = '0;
    #1;
    expect_mem_req("t1_req");
    check_output("t1_req_ready0", 32'(req_ready[0]), 32'd1);
    next_cycle();
    check_output("t1_drained", 32'(mem_req_valid), 32'd0);

    $display("[TB] four simultaneous reads");
    apply_reset();
    mem_req_ready = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_valid[i]  = 1'b1;
      req_packet[i] = make_pkt(bus_read_data, i, 32'h200 + 32'(i * 4), 32'h0);
      exp_req_q.push_back(req_packet[i]);
    end
    next_cycle();
    req_valid = '0;
    #1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      expect_mem_req($sformatf("t2_grant%0d", i));
      next_cycle();
    end
    check_output("t2_drained", 32'(mem_req_valid), 32'd0);
    req_valid     = 4'b0011;
    req_packet[0] = make_pkt(bus_read_data, 0, 32'h300, 32'h0);
    req_packet[1] = make_pkt(bus_read_data, 1, 32'h304, 32'h0);
    exp_req_q.push_back(req_packet[0]);
    exp_req_q.push_back(req_packet[1]);
    next_cycle();
    req_valid = '0;
    #1;
    expect_mem_req("t2_wrap_p0");
    next_cycle();
    expect_mem_req("t2_wrap_p1");
    next_cycle();

    $display("[TB] stalled grant on port 2, port 1 fills");
    p2 = make_pkt(bus_read_data, 2, 32'h400, 32'h0);
    p3 = make_pkt(bus_read_data, 3, 32'h500, 32'h0);
    for (int k = 0; k < 5; k++) w_pkt[k] = make_pkt(bus_write_data, 1, 32'h600 + 32'(k * 4),
                                                    32'hD000 + 32'(k));
    exp_req_q.push_back(p2);
    exp_req_q.push_back(p3);
    for (int k = 0; k < 4; k++) exp_req_q.push_back(w_pkt[k]);
    mem_req_ready = 1'b0;
    req_valid     = 4'b0100;
    req_packet[2] = p2;
    next_cycle();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_output($sformatf("t3_hold_valid%0d", k), 32'(mem_req_valid), 32'd1);
      check_pkt($sformatf("t3_hold_pkt%0d", k), mem_req_packet, p2);
      if (k == 4) check_output("t3_port1_full", 32'(req_ready[1]), 32'd0);
      req_valid     = 4'b0010;
      req_packet[1] = w_pkt[k];
      if (k == 1) begin
        req_valid[3]  = 1'b1;
        req_packet[3] = p3;
      end
      next_cycle();
    end
    req_valid     = '0;
    mem_req_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      expect_mem_req($sformatf("t3_drain%0d", k));
      next_cycle();
    end
    check_output("t3_no_fifth_write", 32'(mem_req_valid), 32'd0);

    $display("[TB] response routing and ordering");
    pa = make_pkt(bus_read_response, 2, 32'h0, 32'hA);
    pb = make_pkt(bus_read_response, 2, 32'h0, 32'hB);
    pc = make_pkt(bus_read_response, 2, 32'h0, 32'hC);
    pd = make_pkt(bus_read_response, 0, 32'h0, 32'hD);
    rsp_ready      = '0;
    mem_rsp_valid  = 1'b1;
    mem_rsp_packet = pa;
    exp_rsp2_q.push_back(pa);
    #1;
    check_output("t5_ready_a", 32'(mem_rsp_ready), 32'd1);
    next_cycle();
    check_output("t5_latency", 32'(rsp_valid), 32'h4);
    mem_rsp_packet = pb;
    exp_rsp2_q.push_back(pb);
    #1;
    check_output("t5_ready_b", 32'(mem_rsp_ready), 32'd1);
    next_cycle();
    mem_rsp_packet = pc;
    #1;
    check_output("t5_full_ready", 32'(mem_rsp_ready), 32'd0);
    mem_rsp_packet = pd;
    exp_rsp0_q.push_back(pd);
    #1;
    check_output("t5_other_port_ready", 32'(mem_rsp_ready), 32'd1);
    next_cycle();
    mem_rsp_valid = 1'b0;
    #1;
    check_output("t5_valids", 32'(rsp_valid), 32'h5);
    expect_rsp(0, "t5_rsp_d");
    expect_rsp(2, "t5_rsp_a");
    rsp_ready = 4'b0101;
    next_cycle();
    check_output("t5_valids_after_pop", 32'(rsp_valid), 32'h4);
    expect_rsp(2, "t5_rsp_b");
    next_cycle();
    check_output("t5_empty", 32'(rsp_valid), 32'h0);
    rsp_ready = '0;

    $display("[TB] bad source response");
    pbad           = make_pkt(bus_read_response, 7, 32'h0, 32'hEE);
    mem_rsp_valid  = 1'b1;
    mem_rsp_packet = pbad;
    #1;
    check_output("t6_bad_ready", 32'(mem_rsp_ready), 32'd1);
    check_output("t6_err_before", 32'(err_bad_source), 32'd0);
    next_cycle();
    mem_rsp_valid  = 1'b0;
    mem_rsp_packet = '0;
    #1;
    check_output("t6_err_set", 32'(err_bad_source), 32'd1);
    check_output("t6_no_rsp", 32'(rsp_valid), 32'h0);
    next_cycle();
    next_cycle();
    check_output("t6_err_sticky", 32'(err_bad_source), 32'd1);

    $display("[TB] reset in the middle of traffic");
    mem_req_ready = 1'b0;
    req_valid     = 4'hF;
    for (int i = 0; i < NUM_PORTS; i++)
      req_packet[i] = make_pkt(bus_write_data, i, 32'h700 + 32'(i), 32'h1);
    mem_rsp_valid  = 1'b1;
    mem_rsp_packet = make_pkt(bus_read_response, 1, 32'h0, 32'h55);
    next_cycle();
    next_cycle();
    check_output("t7_busy_req", 32'(mem_req_valid), 32'd1);
    check_output("t7_busy_rsp", 32'(rsp_valid), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check_output("t7_rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check_output("t7_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("t7_rst_req_ready", 32'(req_ready), 32'h0);
    check_output("t7_rst_err", 32'(err_bad_source), 32'd0);
    apply_stimulus_idle();
    next_cycle();
    reset = 1'b0;
    #1;
    check_output("t7_post_req_ready", 32'(req_ready), 32'hF);
    next_cycle();
    check_output("t7_post_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check_output("t7_post_rsp_valid", 32'(rsp_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_port_memory_bus.md
# multi_port_memory_bus

Parametrised N-requester memory bus that replaces the single-entry request/response handshake with buffered valid/ready channels. Each requester port has its own request FIFO and response FIFO. A round-robin arbiter merges requests onto one memory-side request channel. Memory responses are routed back to the requester named in the packet's `source` field. The block sits between the core-side clients (fetch, load/store, DMA) and the DRAM controller.

## Interface
Parameters:
- `NUM_PORTS`, 4, number of requester ports, 2..8.
- `REQ_DEPTH`, 4, entries per request FIFO, power of two, ≥2.
- `RSP_DEPTH`, 4, entries per response FIFO, power of two, ≥2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  [NUM_PORTS]  requester i offers `req_packet[i]`.
- `req_packet`  in  BusPacket[NUM_PORTS]  request packet; `source` must equal i.
- `req_ready`  out  [NUM_PORTS]  request FIFO i is not full.
- `rsp_valid`  out  [NUM_PORTS]  response FIFO i is non-empty.
- `rsp_packet`  out  BusPacket[NUM_PORTS]  head of response FIFO i.
- `rsp_ready`  in  [NUM_PORTS]  requester i pops its response.
- `mem_req_valid`  out  1  a granted request is presented to memory.
- `mem_req_packet`  out  BusPacket  the granted request, unmodified.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_rsp_valid`  in  1  memory offers a response.
- `mem_rsp_packet`  in  BusPacket  response; `source` selects the destination port.
- `mem_rsp_ready`  out  1  the block accepts the memory response.
- `err_bad_source`  out  1  sticky flag; a response named a port ≥ NUM_PORTS.

## Operation
- A transfer occurs on a rising edge where valid and ready are both 1. This applies to every channel.
- `req_ready[i]` = !full(req FIFO i).
  - No push when full, even if the same cycle pops.
  - Forced 0 while `reset` is asserted.
- Arbiter: round-robin over ports whose request FIFO is non-empty, starting the search at `rr_ptr`.
  - On each mem_req transfer, `rr_ptr` ← grant+1, mod NUM_PORTS.
- Grant lock: while `mem_req_valid && !mem_req_ready`, the grant index and `mem_req_packet` stay constant.
  - A newly non-empty higher-priority port does not pre-empt the held grant.
- A mem_req transfer pops the head of the granted request FIFO.
- `packet_type` (`bus_read_data`, `bus_write_data`), address and payload pass through unchanged.
- The block generates no write responses.
- Response routing: dest = `mem_rsp_packet.source`.
  - dest < NUM_PORTS: `mem_rsp_ready` = !full(rsp FIFO dest). On transfer, push to that FIFO.
  - dest ≥ NUM_PORTS: `mem_rsp_ready` = 1. The packet is dropped and `err_bad_source` ← 1 until reset.
- Ordering: FIFO order per port is preserved in both directions. There is no ordering guarantee across ports.
- Occupancy counters are $clog2(DEPTH)+1 bits wide. Read/write pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset values:
  - all FIFOs empty; `rr_ptr` = 0;
  - `req_ready` = 0 during reset, 1 from the first cycle after release;
  - `rsp_valid` = 0, `mem_req_valid` = 0, `mem_rsp_ready` = 1, `err_bad_source` = 0;
  - packet outputs = 0.
- Request latency: accepted at edge N, `mem_req_valid` is at earliest 1 in cycle N+1. The FIFOs are not fall-through.
- Response latency: accepted at edge M, `rsp_valid[dest]` = 1 in cycle M+1.
- Throughput: one memory request and one memory response per cycle, concurrently. Each port can push and pop in the same cycle when not full.
- Reset mid-operation discards all buffered packets immediately (asynchronous). The memory side must drop in-flight responses too.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.

## Configuration
- `MEMORY_BUS_TRACE_EN` defined: `$display` on every mem_req transfer (port, type, address) and every response push (port, payload). An additional `$display` fires when `err_bad_source` is set.
- Undefined: no display statements. RTL behaviour is identical.

## Structure
- Package `memory_bus_pkg` holds `BusPacket`, `bus_packet_type_t` (`bus_read_data`, `bus_write_data`, `bus_read_response`), `BusID`, `memory_address_t` and `bus_packet_payload_t`.
- Sub-module `bus_packet_fifo #(DEPTH)`:
  - push/pop, full/empty, head output;
  - instantiated 2×NUM_PORTS times.
- Arbiter and routing logic live in the top-level module.

## Test plan
- Reset, then port 0 sends read addr 0x100 with mem_req_ready=1 → `mem_req_valid` in the next cycle, packet unchanged, `req_ready[0]` stays 1.
- Ports 0–3 each push one read in the same cycle, mem_req_ready=1 → grants in order 0,1,2,3 on consecutive cycles; `rr_ptr` = 0 afterwards.
- mem_req_ready held 0 for 5 cycles while port 2 is granted and port 1 fills → packet constant for all 5 cycles. After ready rises, the next grant is port 3 if it is pending, else port 1.
- Push 4 writes on port 1 (REQ_DEPTH=4) with mem_req_ready=0 → `req_ready[1]`=0 after the 4th push. A 5th push with valid=1 is not accepted.
- Responses with source=2, payloads 0xA, 0xB while rsp_ready[2]=0 and RSP_DEPTH=2 → FIFO full, `mem_rsp_ready`=0. Pop → 0xA then 0xB in order.
- Response with source=7 (NUM_PORTS=4) → accepted, no rsp_valid rises, `err_bad_source`=1 until reset. Asserting reset mid-burst clears all valids at once.
